inc_count_reg: RTL and testbench

- Registered 4-bit modulo counter stage. It holds the count value and feeds it to the team's combinational `incrementor` each cycle.
- It consumes the `incrementor` sum/overflow to produce the next state, and adds load, enable, modulus wrap, one-shot halt, and wrap statistics.
- It sits directly upstream and downstream of `incrementor`. It is the register/control stage that turns that adder into a usable counter for timers and sequencers.

---
 rtl/inc_pkg.sv | 12 +
 rtl/inc_count_reg_if.sv | 32 +++
 rtl/incrementor.sv | 12 +
 rtl/inc_count_reg.sv | 99 +++++++++
 tb/tb_inc_count_reg.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/inc_pkg.sv
// Shared types and constants for the registered modulo counter stage.
package inc_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } inc_state_t;

endpackage

// File: rtl/inc_count_reg_if.sv
// Control/status bundle between the counter stage and its user.
interface inc_count_reg_if
   import inc_pkg::*;
#(
   parameter int unsigned WRAP_W = 8
) ();

   logic              en;
   logic              load;
   logic [CNT_W-1:0]  load_val;
   logic              one_shot;
   logic              clr_stat;
   logic [CNT_W-1:0]  count;
   logic              tc;
   logic              ovf_pulse;
   logic              ovf_sticky;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              busy;

   // Counter side
   modport slave (
      input  en, load, load_val, one_shot, clr_stat,
      output count, tc, ovf_pulse, ovf_sticky, wrap_cnt, busy
   );

   // User side
   modport master (
      output en, load, load_val, one_shot, clr_stat,
      input  count, tc, ovf_pulse, ovf_sticky, wrap_cnt, busy
   );

endinterface

// File: rtl/incrementor.sv
// Combinational +1 adder with carry-out.
module incrementor
   import inc_pkg::*;
(
   input  logic [CNT_W-1:0] in,
   output logic [CNT_W-1:0] out,
   output logic             overflow
);

   assign {overflow, out} = {1'b0, in} + {{CNT_W{1'b0}}, 1'b1};

endmodule

// File: rtl/inc_count_reg.sv
// Register/control stage around the incrementor: load, enable, modulus wrap,
// one-shot halt and wrap statistics. All outputs come from flops except tc,
// which is decoded from the count register only.
module inc_count_reg
   import inc_pkg::*;
#(
   parameter logic [CNT_W-1:0] MOD_MAX = 4'd15,
   parameter int unsigned      WRAP_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   inc_count_reg_if.slave  bus
);

   localparam logic [WRAP_W-1:0] WrapMax = {WRAP_W{1'b1}};
   localparam logic [WRAP_W-1:0] WrapOne = {{(WRAP_W-1){1'b0}}, 1'b1};

   inc_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_pulse_q, ovf_pulse_d;
   logic              ovf_sticky_q, ovf_sticky_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic              busy_q;

   logic [CNT_W-1:0]  inc_out;
   logic              inc_ovf;
   logic              wrap;
   logic [WRAP_W-1:0] wrap_base;

   incrementor u_incrementor (
      .in       (count_q),
      .out      (inc_out),
      .overflow (inc_ovf)
   );

   // Next state, count and statistics; load beats en, wrap beats clr_stat
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      ovf_pulse_d  = 1'b0;
      ovf_sticky_d = ovf_sticky_q;
      wrap_cnt_d   = wrap_cnt_q;
      wrap         = 1'b0;

      if (bus.load) begin
         count_d = bus.load_val;
         if (state_q == DONE) begin
            state_d = IDLE;
         end
      end else if (bus.en && (state_q != DONE)) begin
         // Out-of-range loaded values also wrap here
         if ((count_q >= MOD_MAX) || inc_ovf) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = inc_out;
         end
         state_d = (wrap && bus.one_shot) ? DONE : RUN;
      end

      wrap_base = bus.clr_stat ? '0 : wrap_cnt_q;
      if (bus.clr_stat) begin
         ovf_sticky_d = 1'b0;
         wrap_cnt_d   = '0;
      end
      if (wrap) begin
         ovf_pulse_d  = 1'b1;
         ovf_sticky_d = 1'b1;
         wrap_cnt_d   = (wrap_base == WrapMax) ? wrap_base : wrap_base + WrapOne;
      end
   end

   // All state and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         ovf_pulse_q  <= 1'b0;
         ovf_sticky_q <= 1'b0;
         wrap_cnt_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         ovf_pulse_q  <= ovf_pulse_d;
         ovf_sticky_q <= ovf_sticky_d;
         wrap_cnt_q   <= wrap_cnt_d;
         busy_q       <= (state_d == RUN);
      end
   end

   assign bus.count      = count_q;
   assign bus.tc         = (count_q == MOD_MAX);
   assign bus.ovf_pulse  = ovf_pulse_q;
   assign bus.ovf_sticky = ovf_sticky_q;
   assign bus.wrap_cnt   = wrap_cnt_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_inc_count_reg.sv
// Bench for inc_count_reg: three instances (MOD_MAX/WRAP_W = 15/8, 9/8, 15/2)
// share one stimulus stream and are checked every cycle against a counter model.
module tb_inc_count_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, load, one_shot, clr_stat;
   logic [3:0] load_val;

   always #5 clk = ~clk;

   inc_count_reg_if #(.WRAP_W(8)) bus_a ();
   inc_count_reg_if #(.WRAP_W(8)) bus_b ();
   inc_count_reg_if #(.WRAP_W(2)) bus_c ();

   assign bus_a.en = en;        assign bus_b.en = en;        assign bus_c.en = en;
   assign bus_a.load = load;    assign bus_b.load = load;    assign bus_c.load = load;
   assign bus_a.load_val = load_val;
   assign bus_b.load_val = load_val;
   assign bus_c.load_val = load_val;
   assign bus_a.one_shot = one_shot;
   assign bus_b.one_shot = one_shot;
   assign bus_c.one_shot = one_shot;
   assign bus_a.clr_stat = clr_stat;
   assign bus_b.clr_stat = clr_stat;
   assign bus_c.clr_stat = clr_stat;

   inc_count_reg #(.MOD_MAX(4'd15), .WRAP_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   inc_count_reg #(.MOD_MAX(4'd9),  .WRAP_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   inc_count_reg #(.MOD_MAX(4'd15), .WRAP_W(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   int checks = 0;
   int errors = 0;

   // Model: mode 0 = idle, 1 = running, 2 = halted after a one-shot wrap
   int m_mod [3] = '{15, 9, 15};
   int m_wmax[3] = '{255, 255, 3};
   int m_mode[3];
   int m_cnt [3];
   int m_pls [3];
   int m_stk [3];
   int m_wrp [3];

   int o_cnt[3], o_tc[3], o_pls[3], o_stk[3], o_wrp[3], o_busy[3];
   string nm[3] = '{"a", "b", "c"};

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         bit wrapped = 0;
         m_pls[k] = 0;
         if (rst) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_stk[k] = 0; m_wrp[k] = 0;
         end else begin
            if (load) begin
               m_cnt[k] = int'(load_val);
               if (m_mode[k] == 2) m_mode[k] = 0;
            end else if (en && m_mode[k] != 2) begin
               if (m_cnt[k] >= m_mod[k]) begin
                  m_cnt[k] = 0;
                  wrapped = 1;
               end else begin
                  m_cnt[k] = m_cnt[k] + 1;
               end
               m_mode[k] = (wrapped && one_shot) ? 2 : 1;
            end
            if (clr_stat) begin
               m_stk[k] = 0; m_wrp[k] = 0;
            end
            if (wrapped) begin
               m_pls[k] = 1;
               m_stk[k] = 1;
               if (m_wrp[k] < m_wmax[k]) m_wrp[k] = m_wrp[k] + 1;
            end
         end
      end
   endtask

   task automatic sample();
      o_cnt[0] = int'(bus_a.count); o_tc[0] = int'(bus_a.tc); o_pls[0] = int'(bus_a.ovf_pulse);
      o_stk[0] = int'(bus_a.ovf_sticky); o_wrp[0] = int'(bus_a.wrap_cnt);
      o_busy[0] = int'(bus_a.busy);
      o_cnt[1] = int'(bus_b.count); o_tc[1] = int'(bus_b.tc); o_pls[1] = int'(bus_b.ovf_pulse);
      o_stk[1] = int'(bus_b.ovf_sticky); o_wrp[1] = int'(bus_b.wrap_cnt);
      o_busy[1] = int'(bus_b.busy);
      o_cnt[2] = int'(bus_c.count); o_tc[2] = int'(bus_c.tc); o_pls[2] = int'(bus_c.ovf_pulse);
      o_stk[2] = int'(bus_c.ovf_sticky); o_wrp[2] = int'(bus_c.wrap_cnt);
      o_busy[2] = int'(bus_c.busy);
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk({nm[k], ".count"},      o_cnt[k],  m_cnt[k]);
         chk({nm[k], ".tc"},         o_tc[k],   (m_cnt[k] == m_mod[k]) ? 1 : 0);
         chk({nm[k], ".ovf_pulse"},  o_pls[k],  m_pls[k]);
         chk({nm[k], ".ovf_sticky"}, o_stk[k],  m_stk[k]);
         chk({nm[k], ".wrap_cnt"},   o_wrp[k],  m_wrp[k]);
         chk({nm[k], ".busy"},       o_busy[k], (m_mode[k] == 1) ? 1 : 0);
      end
   endtask

   // One clock: inputs are already set, sample #1 after the edge
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      sample();
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; load = 1'b0; clr_stat = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0; one_shot = 1'b0; clr_stat = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = 0; m_cnt[k] = 0; m_pls[k] = 0; m_stk[k] = 0; m_wrp[k] = 0;
      end
      #2;

      // Reset values
      do_reset();
      chk("reset.count", o_cnt[0], 0);
      chk("reset.tc",    o_tc[0],  0);

      // Free-run 17 cycles at MOD_MAX = 15
      one_shot = 1'b0; en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         chk("free.seq",   o_cnt[0], (i + 1) % 16);
         chk("free.pulse", o_pls[0], (i == 15) ? 1 : 0);
      end
      chk("free.wrap_cnt", o_wrp[0], 1);
      chk("free.sticky",   o_stk[0], 1);

      // One-shot at MOD_MAX = 9 halts in DONE, then load leaves it
      do_reset();
      one_shot = 1'b1; en = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("oneshot.count", o_cnt[1], 0);
      chk("oneshot.busy",  o_busy[1], 0);
      load = 1'b1; load_val = 4'd4;
      step();
      load = 1'b0;
      chk("oneshot.load",  o_cnt[1], 4);
      chk("oneshot.idle",  o_busy[1], 0);

      // load and en together at count 3
      do_reset();
      one_shot = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      load = 1'b1; load_val = 4'd7;
      step();
      chk("load_en.count", o_cnt[0], 7);
      chk("load_en.pulse", o_pls[0], 0);

      // Out-of-range load wraps on next advance
      load_val = 4'd12; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1;
      step();
      chk("oor.count", o_cnt[1], 0);
      chk("oor.pulse", o_pls[1], 1);

      // clr_stat on the same edge as a wrap
      load = 1'b1; load_val = 4'd9; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1; clr_stat = 1'b1;
      step();
      clr_stat = 1'b0;
      chk("clr_wrap.sticky",   o_stk[1], 1);
      chk("clr_wrap.wrap_cnt", o_wrp[1], 1);

      // Saturation of a 2-bit wrap counter after 5 wraps
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 80; i++) step();
      chk("sat.c_wrap_cnt", o_wrp[2], 3);
      chk("sat.a_wrap_cnt", o_wrp[0], 5);

      // rst mid-run beats load and en
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("rst_mid.pre", o_cnt[0], 6);
      rst = 1'b1; load = 1'b1; load_val = 4'd5;
      step();
      chk("rst_mid.count", o_cnt[0], 0);
      chk("rst_mid.busy",  o_busy[0], 0);
      rst = 1'b0; load = 1'b0;
      step();
      chk("rst_mid.next", o_cnt[0], 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 63) == 0);
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         en       = ($urandom_range(0, 3) != 0);
         clr_stat = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
